traffic_phase_scheduler: RTL
============================

// Module: traffic_phase_scheduler
// PURPOSE
// Schedules right-of-way between NUM_PH intersection approaches that share one
// conflict zone. Arbitrates vehicle sensor requests round-robin, gives emergency
// requests pre-emptive priority, and sequences each phase through GREEN, YELLOW
// and ALL_RED. Sits above the per-phase light drivers and feeds them the lights bus.
// PARAMETERS
// NUM_PH     4    number of phases/requesters (2..8)
// TW         8    width of timer and max_green
// MIN_GREEN  10   minimum green cycles (>=1)
// YELLOW_T   4    yellow cycles, exact (>=1)
// ALLRED_T   2    all-red clearance cycles, exact (>=1)
// PORTS
// clk          in   1         rising-edge clock
// reset        in   1         synchronous reset, active-low
// req          in   NUM_PH    level request per phase (vehicle sensor)
// emerg_valid  in   1         emergency pre-emption request, level
// emerg_phase  in   3         phase index requested by emergency
// max_green    in   TW        max-out limit in cycles; 0 = no max-out
// grant        out  NUM_PH    one-hot phase currently green/yellow; 0 in ALL_RED
// lights       out  3*NUM_PH  per phase {R,Y,G}: 100 red, 010 yellow, 001 green
// state        out  2         0 ALL_RED, 1 GREEN, 2 YELLOW
// elapsed      out  TW        cycles spent in current state, saturating
// BEHAVIOUR
// - All outputs registered. On clk edge with reset==0: state=ALL_RED, elapsed=0,
//   grant=0, lights all 100, rr pointer last=NUM_PH-1. Reset wins at any point,
//   mid-GREEN/YELLOW included; the next edge is all-red.
// - elapsed: 0 on the first cycle of every state, +1 per cycle, saturates at 2^TW-1.
// - ALL_RED: lasts exactly ALLRED_T cycles; the decision is made in the cycle with
//   elapsed==ALLRED_T-1:
//   emerg_valid && emerg_phase<NUM_PH -> GREEN on emerg_phase;
//   else any req -> GREEN on the first req found searching last+1, last+2, .. mod NUM_PH;
//   else stay ALL_RED (elapsed keeps counting, decision re-evaluated every cycle).
//   Entering GREEN sets grant and last=granted index.
// - GREEN (phase g), exit to YELLOW when any of these holds:
//   pre-empt: emerg_valid && emerg_phase!=g && emerg_phase<NUM_PH (ignores MIN_GREEN);
//   gap-out: elapsed>=MIN_GREEN-1 && !req[g] && other = |(req & ~grant);
//   max-out: max_green!=0 && elapsed>=max(max_green,MIN_GREEN)-1 && other.
//   Emergency on g itself blocks gap/max-out while asserted. With no competing
//   request, green rests indefinitely.
// - YELLOW: exactly YELLOW_T cycles, then ALL_RED. Yellow and all-red are never
//   shortened, even by emergency; the emergency is served at the next ALL_RED decision.
// - Green interval length = elapsed at the exit decision + 1. lights and grant
//   change on the same edge as state.
// - emerg_phase>=NUM_PH: treated as no emergency.
// - Invariant: at most one phase non-red; a phase change always passes through
//   YELLOW_T + ALLRED_T cycles.
// - req/max_green are sampled every cycle; changing max_green mid-green applies
//   immediately.
// TESTING (NUM_PH=4, MIN_GREEN=10, YELLOW_T=4, ALLRED_T=2)
// 1 reset low 3 cyc, release, req=0 -> lights=12'h924, grant=0, state=0 for 100 cyc
// 2 req=0001 held, max_green=20 -> grant=0001 after 2 all-red cyc; green holds 50+ cyc
// 3 sc.2 plus req[2]=1 at green elapsed 3 -> 20 green, 4 yellow, 2 all-red, grant=0100
// 4 req[0] green, req[1]=1, req[0] drops at elapsed 5 -> exactly 10 green cyc, then grant=0010
// 5 req=1111 held, max_green=12 -> grants 0001,0010,0100,1000,0001; each green 12 cyc
// 6 phase 0 green elapsed 2, emerg_valid=1 phase 3 -> 3 green, 4 yellow, 2 all-red,
//   grant=1000; then reset low mid-green -> next edge lights=12'h924, grant=0

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Right-of-way scheduler for NUM_PH approaches sharing one conflict zone:
// round-robin vehicle arbitration, emergency pre-emption, GREEN/YELLOW/ALL_RED sequencing.
module traffic_phase_scheduler #(
    parameter int NUM_PH    = 4,
    parameter int TW        = 8,
    parameter int MIN_GREEN = 10,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PH-1:0]     req,
    input  logic                  emerg_valid,
    input  logic [2:0]            emerg_phase,
    input  logic [TW-1:0]         max_green,
    output logic [NUM_PH-1:0]     grant,
    output logic [3*NUM_PH-1:0]   lights,
    output logic [1:0]            state,
    output logic [TW-1:0]         elapsed
);

    localparam int IW = (NUM_PH > 1) ? $clog2(NUM_PH) : 1;
    localparam logic [TW-1:0] EL_MAX = {TW{1'b1}};

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } ph_state_t;

    ph_state_t             state_r;
    ph_state_t             state_nxt_s;
    logic [TW-1:0]         elapsed_r;
    logic [IW-1:0]         idx_r;
    logic [IW-1:0]         idx_nxt_s;
    logic [IW-1:0]         last_r;
    logic [NUM_PH-1:0]     grant_r;
    logic [3*NUM_PH-1:0]   lights_r;

    logic [31:0]           el_w_s;
    logic [31:0]           max_lim_s;
    logic                  emerg_ok_s;
    logic                  emerg_on_g_s;
    logic [IW-1:0]         emerg_idx_s;
    logic                  other_s;
    logic                  gap_out_s;
    logic                  max_out_s;
    logic                  pre_empt_s;
    logic [IW:0]           pick_s;

    // First requester after 'last' in circular order; MSB flags that one was found.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    function automatic logic [IW:0] rr_pick(input logic [NUM_PH-1:0] r,
                                            input logic [IW-1:0]     last);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = NUM_PH; k >= 1; k--) begin
            j = (int'(last) + k) % NUM_PH;
            if (r[j]) begin
                res = {1'b1, IW'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_PH-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_PH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [3*NUM_PH-1:0] build_lights(input ph_state_t     st,
                                                         input logic [IW-1:0] idx);
        logic [3*NUM_PH-1:0] l;
        for (int i = 0; i < NUM_PH; i++) begin
            if ((i == int'(idx)) && (st == ST_GREEN)) begin
                l[3*i +: 3] = 3'b001;
            end else if ((i == int'(idx)) && (st == ST_YELLOW)) begin
                l[3*i +: 3] = 3'b010;
            end else begin
                l[3*i +: 3] = 3'b100;
            end
        end
        return l;
    endfunction

    // Exit conditions for the current green and the all-red arbitration inputs.
    always_comb begin
        el_w_s       = 32'(elapsed_r);
        max_lim_s    = (32'(max_green) > 32'(MIN_GREEN)) ? 32'(max_green) : 32'(MIN_GREEN);
        emerg_ok_s   = emerg_valid && (32'(emerg_phase) < 32'(NUM_PH));
        emerg_idx_s  = IW'(emerg_phase);
        emerg_on_g_s = emerg_ok_s && (32'(emerg_phase) == 32'(idx_r));
        other_s      = |(req & ~grant_r);
        pre_empt_s   = emerg_ok_s && !emerg_on_g_s;
        gap_out_s    = (el_w_s >= 32'(MIN_GREEN - 1)) && !req[idx_r] && other_s;
        max_out_s    = (max_green != {TW{1'b0}}) && (el_w_s >= (max_lim_s - 32'd1)) && other_s;
        pick_s       = rr_pick(req, last_r);
    end

    // Phase sequencing decision.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_ALL_RED: begin
                if (el_w_s >= 32'(ALLRED_T - 1)) begin
                    if (emerg_ok_s) begin
                        state_nxt_s = ST_GREEN;
                        idx_nxt_s   = emerg_idx_s;
                    end else if (pick_s[IW]) begin
                        state_nxt_s = ST_GREEN;
                        idx_nxt_s   = pick_s[IW-1:0];
                    end else begin
                        state_nxt_s = ST_ALL_RED;
                    end
                end else begin
                    state_nxt_s = ST_ALL_RED;
                end
            end
            ST_GREEN: begin
                if (pre_empt_s || (!emerg_on_g_s && (gap_out_s || max_out_s))) begin
                    state_nxt_s = ST_YELLOW;
                end else begin
                    state_nxt_s = ST_GREEN;
                end
            end
            ST_YELLOW: begin
                if (el_w_s >= 32'(YELLOW_T - 1)) begin
                    state_nxt_s = ST_ALL_RED;
                end else begin
                    state_nxt_s = ST_YELLOW;
                end
            end
            default: begin
                state_nxt_s = ST_ALL_RED;
            end
        endcase
    end

    // State, timer, round-robin pointer and registered light/grant outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_ALL_RED;
            elapsed_r <= {TW{1'b0}};
            idx_r     <= {IW{1'b0}};
            last_r    <= IW'(NUM_PH - 1);
            grant_r   <= {NUM_PH{1'b0}};
            lights_r  <= build_lights(ST_ALL_RED, {IW{1'b0}});
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            if (state_nxt_s != state_r) begin
                elapsed_r <= {TW{1'b0}};
            end else if (elapsed_r != EL_MAX) begin
                elapsed_r <= elapsed_r + {{(TW-1){1'b0}}, 1'b1};
            end else begin
                elapsed_r <= elapsed_r;
            end
            if ((state_r == ST_ALL_RED) && (state_nxt_s == ST_GREEN)) begin
                last_r <= idx_nxt_s;
            end else begin
                last_r <= last_r;
            end
            grant_r  <= (state_nxt_s == ST_ALL_RED) ? {NUM_PH{1'b0}} : onehot(idx_nxt_s);
            lights_r <= build_lights(state_nxt_s, idx_nxt_s);
        end
    end

    assign grant   = grant_r;
    assign lights  = lights_r;
    assign state   = state_r;
    assign elapsed = elapsed_r;

endmodule
